sevenseg_scan_ctrl: RTL and testbench
=====================================

Name: sevenseg_scan_ctrl

Overview:
Parametrised N-digit multiplexed seven-segment display controller for the board's common-anode display. It takes a per-digit byte bus with hex, leading-zero-suppressed hex or raw-segment modes, plus per-digit blanking and PWM brightness. Display updates go through a shadow register and are applied atomically at frame boundaries, so the display never tears. It sits in swervolf_core behind the GPIO/peripheral register block and drives AN and CA..CG/DP.

Parameters:
NUM_DIGITS, 8, digits scanned (2..16)
CLK_FREQ_HZ, 50_000_000, clk frequency
REFRESH_HZ, 1000, full-frame refresh rate
BRIGHT_W, 4, brightness code width
GUARD_CYC, 16, all-anodes-off cycles at the start of each slot (anti-ghosting)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
load_i  in  1  one-cycle strobe: capture data_i/mode_i/en_i/bright_i into shadow
data_i  in  8*NUM_DIGITS  byte d per digit; hex modes use d[3:0] with dp=d[7]; raw mode uses d[6:0]={a..g}, d[7]=dp (1=lit)
mode_i  in  2  0=hex, 1=hex with leading-zero suppression, 2=raw, 3=reserved (treated as raw)
en_i  in  NUM_DIGITS  per-digit enable; 0 blanks the digit
bright_i  in  BRIGHT_W  brightness code
an_n_o  out  NUM_DIGITS  anode selects, active-low
seg_n_o  out  7  {CA..CG}, active-low, bit6=CA
dp_n_o  out  1  decimal point, active-low
pending_o  out  1  shadow holds an update not yet applied
frame_o  out  1  one-cycle pulse at the last cycle of a frame

Behaviour:
- SLOT_CYC = CLK_FREQ_HZ/(REFRESH_HZ*NUM_DIGITS), integer division. Elaboration error if SLOT_CYC <= GUARD_CYC.
- slot_cnt counts 0..SLOT_CYC-1. At SLOT_CYC-1 it wraps and scan_idx advances; scan_idx wraps NUM_DIGITS-1 -> 0.
- Frame boundary: slot_cnt==SLOT_CYC-1 and scan_idx==NUM_DIGITS-1. frame_o is high for exactly that cycle.
- Brightness: on_cyc = ((bright+1)*SLOT_CYC) >> BRIGHT_W. The anode for scan_idx is active when GUARD_CYC <= slot_cnt < on_cyc and en[scan_idx]==1; otherwise all anodes are off. If on_cyc <= GUARD_CYC the digit is never lit.
- Segment decode uses the active registers only, never the shadow:
  - hex: standard 0-F glyphs.
  - raw: byte bits pass straight through.
  - Leading-zero suppression (mode 1): digit k (k>=1) is blanked when its nibble and every higher digit's nibble are all 0. Digit 0 is never suppressed. DP is not suppressed.
- Outputs are registered: one cycle of latency from counter state to an_n_o/seg_n_o/dp_n_o. Segments for a blanked or off digit are all 1.
- Shadow handshake:
  - load_i writes the shadow and sets pending.
  - At a frame boundary with pending=1, shadow is copied to active and pending clears.
  - A load while pending overwrites the shadow; last write wins.
  - A load on the frame-boundary cycle writes input data directly to active and shadow, and leaves pending=0.
- Reset (async, any time, including mid-frame): slot_cnt=0, scan_idx=0, pending=0, frame_o=0, an_n_o all 1, seg_n_o=7'h7F, dp_n_o=1. Active and shadow registers reset to: data 0, mode 0, en 0 (display blank), bright all-ones.
- Counters and decode run continuously. No stalls.

Decomposition:
- sevenseg_pkg:
  - mode enum (MODE_HEX, MODE_HEX_LZ, MODE_RAW)
  - 16-entry active-low glyph constant array
  - SEG_BLANK = 7'h7F
  - slot_len() function
- One combinational sub-module, sevenseg_hex_decode: nibble -> active-low 7-bit glyph. Leading-zero logic stays in the top.

Test Plan:
Bench parameters for all scenarios: NUM_DIGITS=8, CLK_FREQ_HZ=64000, REFRESH_HZ=100, GUARD_CYC=16, BRIGHT_W=4, so SLOT_CYC=80 and one frame = 640 cycles.
1. Reset, then load data=0x0706050403020100, mode 0, en=0xFF, bright=15, and wait for the next frame. Expected: in the following frame digit 0 lights with seg_n=0000001 and digit 1 with 1001111. Each anode is low for exactly 64 cycles (slot cycles 16..79), one at a time, and frame_o pulses every 640 cycles.
2. Same as 1 with bright=7. Expected: each anode is low for 24 cycles. With bright=0 (on_cyc=5) all anodes stay 1 for a whole frame.
3. mode 1, data nibbles 0,0,0,0,0,1,0,0 (MSD first), en=0xFF. Expected: digits 7..3 show seg_n=7F, digit 2 shows 1001111, digits 1 and 0 show 0000001. All nibbles 0: only digit 0 lit.
4. Load A mid-frame, then load B 100 cycles later in the same frame. Expected: pending_o=1 until the boundary, the display stays on the old data until the boundary, then shows B and never A. Load on the exact boundary cycle: new data shows in the next frame with pending_o=0.
5. mode 2, byte 0x81 on digit 0. Expected: seg_n=1111110 (only CG lit) and dp_n=0. en_i=0xFE: digit 0's anode never goes low.
6. Assert rst at slot_cnt=40 while digit 3 is lit. Expected: an_n all 1, seg_n=7F and pending_o=0 in the same cycle, without waiting for a clock edge. After release the display stays blank until a load.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment controller.
// Glyphs are active-low {a,b,c,d,e,f,g} with segment a in bit 6.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    MODE_HEX    = 2'd0,
    MODE_HEX_LZ = 2'd1,
    MODE_RAW    = 2'd2
  } mode_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] GLYPH [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06,
    7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60,
    7'h31, 7'h42, 7'h30, 7'h38
  };

  function automatic int slot_len(
    input int clk_hz,
    input int refresh_hz,
    input int digits
  );
    return clk_hz / (refresh_hz * digits);
  endfunction

endpackage

// File: rtl/sevenseg_hex_decode.sv
// Nibble to active-low seven-segment glyph.
// Purely combinational lookup.
module sevenseg_hex_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = GLYPH[nib_i];

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// N-digit multiplexed common-anode display scanner with PWM brightness,
// leading-zero suppression and frame-synchronous shadow updates.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int REFRESH_HZ  = 1000,
  parameter int BRIGHT_W    = 4,
  parameter int GUARD_CYC   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [8*NUM_DIGITS-1:0] data_i,
  input  logic [1:0]              mode_i,
  input  logic [NUM_DIGITS-1:0]   en_i,
  input  logic [BRIGHT_W-1:0]     bright_i,
  output logic [NUM_DIGITS-1:0]   an_n_o,
  output logic [6:0]              seg_n_o,
  output logic                    dp_n_o,
  output logic                    pending_o,
  output logic                    frame_o
);

  localparam int SLOT_CYC = slot_len(CLK_FREQ_HZ, REFRESH_HZ, NUM_DIGITS);
  localparam int SW = $clog2(SLOT_CYC);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [31:0] SLOT_U = 32'(SLOT_CYC);
  localparam logic [31:0] GUARD_U = 32'(GUARD_CYC);

  if (SLOT_CYC <= GUARD_CYC) begin : g_slot_chk
    $error("sevenseg_scan_ctrl: slot too short for guard time");
  end

  logic [SW-1:0] slot_q, slot_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          slot_end, frame_end;

  logic [8*NUM_DIGITS-1:0] sh_data_q, act_data_q;
  logic [1:0]              sh_mode_q, act_mode_q;
  logic [NUM_DIGITS-1:0]   sh_en_q, act_en_q;
  logic [BRIGHT_W-1:0]     sh_bright_q, act_bright_q;
  logic                    pending_q;

  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic [6:0]            seg_n_q, seg_n_d;
  logic                  dp_n_q, dp_n_d;

  logic [7:0]  cur;
  logic [6:0]  glyph;
  logic [31:0] on_cyc;
  logic        in_win, lit;
  logic        lz_all_zero, lz_blank;

  assign slot_end  = slot_q == SLOT_LAST;
  assign frame_end = slot_end && (idx_q == IDX_LAST);

  always_comb begin
    slot_d = slot_end ? '0 : slot_q + 1'b1;
    idx_d  = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
      idx_q  <= '0;
    end else begin
      slot_q <= slot_d;
      idx_q  <= idx_d;
    end
  end

  // A load on the boundary cycle bypasses the shadow so it is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_data_q    <= '0;
      sh_mode_q    <= '0;
      sh_en_q      <= '0;
      sh_bright_q  <= '1;
      act_data_q   <= '0;
      act_mode_q   <= '0;
      act_en_q     <= '0;
      act_bright_q <= '1;
      pending_q    <= 1'b0;
    end else if (load_i) begin
      sh_data_q   <= data_i;
      sh_mode_q   <= mode_i;
      sh_en_q     <= en_i;
      sh_bright_q <= bright_i;
      pending_q   <= !frame_end;
      if (frame_end) begin
        act_data_q   <= data_i;
        act_mode_q   <= mode_i;
        act_en_q     <= en_i;
        act_bright_q <= bright_i;
      end
    end else if (frame_end && pending_q) begin
      act_data_q   <= sh_data_q;
      act_mode_q   <= sh_mode_q;
      act_en_q     <= sh_en_q;
      act_bright_q <= sh_bright_q;
      pending_q    <= 1'b0;
    end
  end

  always_comb begin
    cur = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) cur = act_data_q[8*k +: 8];
    end
  end

  always_comb begin
    lz_all_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IW'(k) >= idx_q && act_data_q[8*k +: 4] != 4'h0) begin
        lz_all_zero = 1'b0;
      end
    end
  end

  assign lz_blank = (act_mode_q == MODE_HEX_LZ) &&
                    (idx_q != '0) && lz_all_zero;

  sevenseg_hex_decode u_hex (
    .nib_i  (cur[3:0]),
    .seg_n_o(glyph)
  );

  assign on_cyc = ((32'(act_bright_q) + 32'd1) * SLOT_U) >> BRIGHT_W;
  assign in_win = (32'(slot_q) >= GUARD_U) && (32'(slot_q) < on_cyc);
  assign lit    = in_win && act_en_q[idx_q];

  always_comb begin
    an_n_d  = '1;
    seg_n_d = SEG_BLANK;
    dp_n_d  = 1'b1;
    if (lit) begin
      an_n_d = ~(NUM_DIGITS'(1) << idx_q);
      dp_n_d = ~cur[7];
      unique case (1'b1)
        act_mode_q >= MODE_RAW: seg_n_d = ~cur[6:0];
        lz_blank:               seg_n_d = SEG_BLANK;
        default:                seg_n_d = glyph;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_n_q  <= '1;
      seg_n_q <= SEG_BLANK;
      dp_n_q  <= 1'b1;
    end else begin
      an_n_q  <= an_n_d;
      seg_n_q <= seg_n_d;
      dp_n_q  <= dp_n_d;
    end
  end

  assign an_n_o    = an_n_q;
  assign seg_n_o   = seg_n_q;
  assign dp_n_o    = dp_n_q;
  assign pending_o = pending_q;
  assign frame_o   = frame_end;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench: a frame-level model predicts each frame's per-digit
// lit time and glyph; a monitor summarises observed frames and compares.
module tb_sevenseg_scan_ctrl;

  localparam int ND     = 8;
  localparam int CLK_HZ = 64000;
  localparam int REF_HZ = 100;
  localparam int BW     = 4;
  localparam int GUARD  = 16;
  localparam int SLOT   = CLK_HZ / (REF_HZ * ND);
  localparam int FRAME  = SLOT * ND;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_i = 1'b0;
  logic [63:0] data_i = '0;
  logic [1:0]  mode_i = '0;
  logic [7:0]  en_i = '0;
  logic [3:0]  bright_i = '0;
  logic [7:0]  an_n_o;
  logic [6:0]  seg_n_o;
  logic        dp_n_o;
  logic        pending_o;
  logic        frame_o;

  sevenseg_scan_ctrl #(
    .NUM_DIGITS (ND),
    .CLK_FREQ_HZ(CLK_HZ),
    .REFRESH_HZ (REF_HZ),
    .BRIGHT_W   (BW),
    .GUARD_CYC  (GUARD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load_i),
    .data_i   (data_i),
    .mode_i   (mode_i),
    .en_i     (en_i),
    .bright_i (bright_i),
    .an_n_o   (an_n_o),
    .seg_n_o  (seg_n_o),
    .dp_n_o   (dp_n_o),
    .pending_o(pending_o),
    .frame_o  (frame_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  mode;
    logic [7:0]  en;
    logic [3:0]  bright;
  } cfg_t;

  typedef struct packed {
    logic [7:0][9:0] cnt;
    logic [7:0][9:0] first;
    logic [7:0][6:0] seg;
    logic [7:0]      dp;
  } frec_t;

  localparam cfg_t RST_CFG = '{data: 64'h0, mode: 2'd0, en: 8'h0, bright: 4'hF};

  // Lit segments of each hex glyph, by letter.
  string GL [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                     "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                     "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] glyph_of(input int n);
    logic [6:0] s;
    string t;
    int li;
    s = 7'h7F;
    t = GL[n];
    for (int i = 0; i < t.len(); i++) begin
      li = int'(t[i]) - 97;
      s[6-li] = 1'b0;
    end
    return s;
  endfunction

  function automatic frec_t expect_frame(input cfg_t c);
    frec_t r;
    int on, top;
    logic [7:0] b;
    r = '0;
    on = ((int'(c.bright) + 1) * SLOT) / (1 << BW);
    top = -1;
    for (int k = 0; k < ND; k++)
      if (c.data[8*k +: 4] != 4'h0) top = k;
    for (int k = 0; k < ND; k++) begin
      b = c.data[8*k +: 8];
      r.cnt[k] = (c.en[k] && on > GUARD) ? 10'(on - GUARD) : 10'd0;
      r.first[k] = 10'(k * SLOT + GUARD);
      r.dp[k] = ~b[7];
      if (c.mode >= 2'd2) r.seg[k] = ~b[6:0];
      else if (c.mode == 2'd1 && k > 0 && k > top) r.seg[k] = 7'h7F;
      else r.seg[k] = glyph_of(int'(b[3:0]));
    end
    return r;
  endfunction

  cfg_t  m_act, m_sh;
  bit    m_pend;
  int    mcyc;
  frec_t exp_q[$];

  // Reference model: shadow/active handshake, one expected record per frame.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      mcyc = 0;
      m_act = RST_CFG;
      m_sh = RST_CFG;
      m_pend = 1'b0;
      exp_q.delete();
    end else begin
      bit bnd;
      if (mcyc == 0) exp_q.push_back(expect_frame(m_act));
      bnd = (mcyc % FRAME) == FRAME - 1;
      if (load_i) begin
        m_sh = {data_i, mode_i, en_i, bright_i};
        if (bnd) m_act = m_sh;
        m_pend = !bnd;
      end else if (bnd && m_pend) begin
        m_act = m_sh;
        m_pend = 1'b0;
      end
      if (bnd) exp_q.push_back(expect_frame(m_act));
      mcyc++;
    end
  end

  int         samples;
  logic       fr_prev;
  int         acc_cnt [8];
  int         acc_first [8];
  logic [6:0] acc_seg [8];
  logic       acc_dp [8];
  int         viol;

  task automatic clear_acc();
    samples = 0;
    viol = 0;
    for (int k = 0; k < ND; k++) begin
      acc_cnt[k] = 0;
      acc_first[k] = 0;
      acc_seg[k] = 7'h7F;
      acc_dp[k] = 1'b1;
    end
  endtask

  task automatic finalize();
    frec_t e;
    check("frame length", samples, FRAME);
    check("frame anomalies", viol, 0);
    if (exp_q.size() == 0) begin
      check("scoreboard has entry", 0, 1);
    end else begin
      e = exp_q.pop_front();
      for (int k = 0; k < ND; k++) begin
        check($sformatf("d%0d lit cycles", k), acc_cnt[k], int'(e.cnt[k]));
        if (e.cnt[k] != 0) begin
          check($sformatf("d%0d first lit", k), acc_first[k], int'(e.first[k]));
          check($sformatf("d%0d seg_n", k), int'(acc_seg[k]), int'(e.seg[k]));
          check($sformatf("d%0d dp_n", k), int'(acc_dp[k]), int'(e.dp[k]));
        end
      end
    end
    clear_acc();
  endtask

  // Monitor: outputs lag the counters by one cycle, so the last sample of
  // a frame arrives on the cycle after frame_o.
  initial begin
    clear_acc();
    fr_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        clear_acc();
        fr_prev = 1'b0;
      end else if (mcyc > 0) begin
        logic [7:0] low;
        int k1;
        check("pending_o", int'(pending_o), int'(m_pend));
        low = ~an_n_o;
        if ($countones(low) > 1) viol++;
        else if (low == 8'h0) begin
          if (seg_n_o != 7'h7F || dp_n_o != 1'b1) viol++;
        end else begin
          k1 = 0;
          for (int k = 0; k < ND; k++) if (low[k]) k1 = k;
          if (acc_cnt[k1] == 0) begin
            acc_first[k1] = samples;
            acc_seg[k1] = seg_n_o;
            acc_dp[k1] = dp_n_o;
          end else if (acc_seg[k1] != seg_n_o || acc_dp[k1] != dp_n_o) begin
            viol++;
          end
          acc_cnt[k1]++;
        end
        samples++;
        if (fr_prev) finalize();
        else if (samples > FRAME) begin
          check("frame_o period", samples, FRAME);
          clear_acc();
        end
        if (frame_o) check("frame_o phase", mcyc % FRAME, FRAME - 1);
        fr_prev = frame_o;
      end
    end
  end

  task automatic load(input logic [63:0] d, input logic [1:0] m,
                      input logic [7:0] e, input logic [3:0] b);
    data_i = d;
    mode_i = m;
    en_i = e;
    bright_i = b;
    load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
  endtask

  task automatic wait_state(input int s);
    int n;
    n = 0;
    while ((mcyc % FRAME) != s) begin
      @(negedge clk);
      n++;
      if (n > 2 * FRAME) begin
        check("wait_state bound", n, 0);
        break;
      end
    end
  endtask

  task automatic spot(input string nm, input int s, input logic [7:0] an,
                      input logic [6:0] sg, input logic dp);
    wait_state(s + 1);
    check({nm, " an_n"}, int'(an_n_o), int'(an));
    check({nm, " seg_n"}, int'(seg_n_o), int'(sg));
    check({nm, " dp_n"}, int'(dp_n_o), int'(dp));
  endtask

  task automatic count_lows(input string nm, input logic [7:0] mask,
                            input int exp);
    int n;
    n = 0;
    repeat (FRAME) begin
      @(negedge clk);
      if ((~an_n_o & mask) != 8'h0) n++;
    end
    check(nm, n, exp);
  endtask

  task automatic frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    logic [1:0]  m;
    repeat (3) @(negedge clk);
    check("reset an_n", int'(an_n_o), 8'hFF);
    check("reset seg_n", int'(seg_n_o), 7'h7F);
    check("reset pending", int'(pending_o), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    load(64'h0706050403020100, 2'd0, 8'hFF, 4'hF);
    check("pending after load", int'(pending_o), 1);
    wait_state(0);
    spot("hex d0", 20, 8'hFE, 7'b0000001, 1'b1);
    spot("hex d1", SLOT + 20, 8'hFD, 7'b1001111, 1'b1);
    frames(1);

    load(64'h0706050403020100, 2'd0, 8'hFF, 4'h7);
    frames(2);
    load(64'h0706050403020100, 2'd0, 8'hFF, 4'h0);
    wait_state(0);
    count_lows("bright0 anode lows", 8'hFF, 0);

    load(64'h0000000000010000, 2'd1, 8'hFF, 4'hF);
    wait_state(0);
    spot("lz d0", 20, 8'hFE, 7'b0000001, 1'b1);
    spot("lz d2", 2 * SLOT + 20, 8'hFB, 7'b1001111, 1'b1);
    spot("lz d5", 5 * SLOT + 20, 8'hDF, 7'h7F, 1'b1);
    frames(1);
    load(64'h0, 2'd1, 8'hFF, 4'hF);
    frames(2);

    wait_state(100);
    load(64'hAAAA_AAAA_AAAA_AAAA, 2'd0, 8'hFF, 4'hF);
    wait_state(200);
    load(64'h0F0E_0D0C_0B0A_0908, 2'd0, 8'hFF, 4'hF);
    check("pending after overwrite", int'(pending_o), 1);
    wait_state(0);
    check("pending after boundary", int'(pending_o), 0);
    wait_state(FRAME - 1);
    load(64'h1234_5678_9ABC_DEF0, 2'd0, 8'hFF, 4'hF);
    check("pending after boundary load", int'(pending_o), 0);
    frames(1);

    load(64'h81, 2'd2, 8'hFF, 4'hF);
    wait_state(0);
    spot("raw d0", 20, 8'hFE, 7'b1111110, 1'b0);
    frames(1);
    load(64'h81, 2'd2, 8'hFE, 4'hF);
    wait_state(0);
    count_lows("en0 off anode lows", 8'h01, 0);

    load(64'h0706050403020100, 2'd0, 8'hFF, 4'hF);
    wait_state(0);
    wait_state(50);
    load(64'h1111111111111111, 2'd0, 8'hFF, 4'hF);
    wait_state(3 * SLOT + 40);
    check("pre-reset an_n", int'(an_n_o), 8'hF7);
    check("pre-reset pending", int'(pending_o), 1);
    #2 rst = 1'b1;
    #1;
    check("async rst an_n", int'(an_n_o), 8'hFF);
    check("async rst seg_n", int'(seg_n_o), 7'h7F);
    check("async rst dp_n", int'(dp_n_o), 1);
    check("async rst pending", int'(pending_o), 0);
    check("async rst frame_o", int'(frame_o), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    count_lows("blank after reset", 8'hFF, 0);
    frames(1);

    repeat (8) begin
      repeat ($urandom_range(1, FRAME)) @(negedge clk);
      d = {$urandom, $urandom};
      m = 2'($urandom_range(0, 3));
      if (m == 2'd1) d = d >> (8 * $urandom_range(0, 7));
      load(d, m, 8'($urandom), 4'($urandom));
      frames(int'($urandom_range(1, 2)));
    end
    frames(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
